// File: rtl/idma_pkg.sv
// idma_pkg: shared types for the iDMA request arbiter slice.
//   eh_action_e   - error-handling action a frontend can request
//   idma_eh_req_t - per-frontend error-handling request payload
//   arb_state_e   - request arbiter state (IDLE / LOCKED)
//   ARB_MAX_REQ   - largest supported number of frontends
package idma_pkg;

  typedef enum logic [0:0] {
    CONTINUE = 1'b0,
    ABORT    = 1'b1
  } eh_action_e;

  typedef eh_action_e idma_eh_req_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int unsigned ARB_MAX_REQ = 16;

endpackage

// File: rtl/idma_arb_id_fifo.sv
// idma_arb_id_fifo: records the frontend index owning each accepted transfer.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset (pointers only)
//   push_i, data_i     write one owner index (ignored when full)
//   pop_i              drop the head entry (ignored when empty)
//   data_o             head entry (owner of the oldest outstanding transfer)
//   full_o, empty_o    occupancy flags
module idma_arb_id_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [PtrW-1:0]  wr_ptr_d, wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_d, rd_ptr_q;
  logic [Width-1:0] mem_d [Depth];
  logic [Width-1:0] mem_q [Depth];

  // Extra pointer MSB distinguishes full from empty when the addresses match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign data_o  = mem_q[rd_ptr_q[AddrW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push_i && !full_o) begin
      mem_d[wr_ptr_q[AddrW-1:0]] = data_i;
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop_i && !empty_o) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; only entries between the pointers are meaningful.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/idma_req_arbiter.sv
// idma_req_arbiter: shares one iDMA backend between NumReq frontends.
// Round-robin arbitration on the request channel; an owner-ID FIFO routes
// the in-order backend responses (and, optionally, error handling) back to
// the frontend that issued the oldest outstanding transfer.
// Optional feature: define IDMA_ARB_ERROR_HANDLING_EN to forward the error
// handling channel of the head owner; otherwise eh_* inputs are ignored.
// Ports:
//   clk_i, rst_ni                          clock, synchronous active-low reset
//   req_i/req_valid_i/req_ready_o          per-frontend request channel
//   req_o/req_valid_o/req_ready_i          request channel to the backend
//   rsp_i/rsp_valid_i/rsp_ready_o          response channel from the backend
//   rsp_o/rsp_valid_o/rsp_ready_i          response to frontends (valid one-hot)
//   eh_req_i/eh_valid_i/eh_ready_o         per-frontend error handling
//   eh_req_o/eh_valid_o/eh_ready_i         error handling to the backend
//   busy_o                                 transfers outstanding or grant locked
module idma_req_arbiter
  import idma_pkg::*;
#(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned ReqWidth  = 64,
  parameter int unsigned RspWidth  = 32,
  parameter int unsigned NumOutstd = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NumReq*ReqWidth-1:0] req_i,
  input  logic [NumReq-1:0]          req_valid_i,
  output logic [NumReq-1:0]          req_ready_o,
  output logic [ReqWidth-1:0]        req_o,
  output logic                       req_valid_o,
  input  logic                       req_ready_i,
  input  logic [RspWidth-1:0]        rsp_i,
  input  logic                       rsp_valid_i,
  output logic                       rsp_ready_o,
  output logic [RspWidth-1:0]        rsp_o,
  output logic [NumReq-1:0]          rsp_valid_o,
  input  logic [NumReq-1:0]          rsp_ready_i,
  input  logic [NumReq-1:0]          eh_req_i,
  input  logic [NumReq-1:0]          eh_valid_i,
  output logic [NumReq-1:0]          eh_ready_o,
  output idma_eh_req_t               eh_req_o,
  output logic                       eh_valid_o,
  input  logic                       eh_ready_i,
  output logic                       busy_o
);

  localparam int unsigned IdxW = $clog2(NumReq);

  if (NumReq > ARB_MAX_REQ) begin : gen_numreq_check
    $error("idma_req_arbiter: NumReq exceeds ARB_MAX_REQ");
  end

  arb_state_e      state_d, state_q;
  logic [IdxW-1:0] prio_d, prio_q;
  logic [IdxW-1:0] gnt_d, gnt_q;
  logic [IdxW-1:0] cand, idx, sel, head;
  logic            cand_vld, sel_vld;
  logic            fifo_full, fifo_empty, push, pop;

  function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] i);
    return (32'(i) == NumReq - 1) ? '0 : i + 1'b1;
  endfunction

  // First valid frontend at or after prio_q, searched cyclically.
  always_comb begin
    cand     = '0;
    cand_vld = 1'b0;
    idx      = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      idx = IdxW'((32'(prio_q) + i) % NumReq);
      if (!cand_vld && req_valid_i[idx]) begin
        cand_vld = 1'b1;
        cand     = idx;
      end
    end
  end

  // A locked grant keeps forwarding the same frontend until its handshake.
  assign sel     = (state_q == LOCKED) ? gnt_q : cand;
  assign sel_vld = (state_q == LOCKED) ? req_valid_i[gnt_q] : cand_vld;

  always_comb begin
    req_valid_o = sel_vld && !fifo_full;
    req_o       = '0;
    req_ready_o = '0;
    if (req_valid_o) begin
      req_o            = req_i[32'(sel)*ReqWidth +: ReqWidth];
      req_ready_o[sel] = req_ready_i;
    end
  end

  assign push = req_valid_o && req_ready_i;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid_o) begin
          if (req_ready_i) begin
            prio_d = wrap_inc(cand);
          end else begin
            state_d = LOCKED;
            gnt_d   = cand;
          end
        end
      end
      LOCKED: begin
        if (push) begin
          state_d = IDLE;
          prio_d  = wrap_inc(gnt_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      prio_q  <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      gnt_q   <= gnt_d;
    end
  end

  idma_arb_id_fifo #(
    .Depth (NumOutstd),
    .Width (IdxW)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (sel),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Responses are routed only from a registered head; no empty bypass.
  always_comb begin
    rsp_o       = rsp_i;
    rsp_valid_o = '0;
    rsp_ready_o = !fifo_empty && rsp_ready_i[head];
    if (!fifo_empty) begin
      rsp_valid_o[head] = rsp_valid_i;
    end
  end

  assign pop    = rsp_valid_i && rsp_ready_o;
  assign busy_o = !fifo_empty || (state_q == LOCKED);

`ifdef IDMA_ARB_ERROR_HANDLING_EN
  // Only the owner of the oldest transfer may steer error handling; an
  // ABORT leaves the FIFO alone, the resulting error response pops it.
  always_comb begin
    eh_valid_o = !fifo_empty && eh_valid_i[head];
    eh_req_o   = fifo_empty ? CONTINUE : idma_eh_req_t'(eh_req_i[head]);
    eh_ready_o = '0;
    if (!fifo_empty) begin
      eh_ready_o[head] = eh_ready_i;
    end
  end
`else
  logic unused_eh;
  assign unused_eh  = ^{eh_req_i, eh_valid_i, eh_ready_i};
  assign eh_valid_o = 1'b0;
  assign eh_req_o   = CONTINUE;
  assign eh_ready_o = '0;
`endif

endmodule

// File: tb/tb_idma_req_arbiter.sv
module tb_idma_req_arbiter;
  import idma_pkg::*;

  localparam int unsigned NR = 2;
  localparam int unsigned RW = 64;
  localparam int unsigned SW = 32;
  localparam int unsigned NO = 4;

  localparam logic [RW-1:0] P0 = 64'hA0A0_0000_1234_0000;
  localparam logic [RW-1:0] P1 = 64'hB1B1_0000_5678_0001;

  logic               clk = 1'b0;
  logic               rst_ni;
  logic [NR*RW-1:0]   req_i;
  logic [NR-1:0]      req_valid_i;
  logic [NR-1:0]      req_ready_o;
  logic [RW-1:0]      req_o;
  logic               req_valid_o;
  logic               req_ready_i;
  logic [SW-1:0]      rsp_i;
  logic               rsp_valid_i;
  logic               rsp_ready_o;
  logic [SW-1:0]      rsp_o;
  logic [NR-1:0]      rsp_valid_o;
  logic [NR-1:0]      rsp_ready_i;
  logic [NR-1:0]      eh_req_i;
  logic [NR-1:0]      eh_valid_i;
  logic [NR-1:0]      eh_ready_o;
  idma_eh_req_t       eh_req_o;
  logic               eh_valid_o;
  logic               eh_ready_i;
  logic               busy_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  idma_req_arbiter #(
    .NumReq    (NR),
    .ReqWidth  (RW),
    .RspWidth  (SW),
    .NumOutstd (NO)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_o       (req_o),
    .req_valid_o (req_valid_o),
    .req_ready_i (req_ready_i),
    .rsp_i       (rsp_i),
    .rsp_valid_i (rsp_valid_i),
    .rsp_ready_o (rsp_ready_o),
    .rsp_o       (rsp_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .eh_req_i    (eh_req_i),
    .eh_valid_i  (eh_valid_i),
    .eh_ready_o  (eh_ready_o),
    .eh_req_o    (eh_req_o),
    .eh_valid_o  (eh_valid_o),
    .eh_ready_i  (eh_ready_i),
    .busy_o      (busy_o)
  );

  typedef struct {
    logic [1:0]  rv;      // req_valid_i
    logic        rdy;     // req_ready_i
    logic        rspv;    // rsp_valid_i
    logic [1:0]  rsprdy;  // rsp_ready_i
    logic [31:0] rspd;    // rsp_i
    logic        e_rvo;   // expected req_valid_o
    logic [1:0]  e_rro;   // expected req_ready_o
    int          e_sel;   // expected req_o source: 0, 1, or 2 = zero
    logic [1:0]  e_rspvo; // expected rsp_valid_o
    logic        e_rspro; // expected rsp_ready_o
    logic        e_busy;  // expected busy_o
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [1:0] rv, input logic rdy, input logic rspv,
                     input logic [1:0] rsprdy, input logic [31:0] rspd,
                     input logic e_rvo, input logic [1:0] e_rro, input int e_sel,
                     input logic [1:0] e_rspvo, input logic e_rspro,
                     input logic e_busy);
    vec_t v;
    v.rv = rv; v.rdy = rdy; v.rspv = rspv; v.rsprdy = rsprdy; v.rspd = rspd;
    v.e_rvo = e_rvo; v.e_rro = e_rro; v.e_sel = e_sel; v.e_rspvo = e_rspvo;
    v.e_rspro = e_rspro; v.e_busy = e_busy;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] rv, input logic rdy, input logic rspv,
                       input logic [1:0] rsprdy, input logic [31:0] rspd);
    req_valid_i = rv;
    req_ready_i = rdy;
    rsp_valid_i = rspv;
    rsp_ready_i = rsprdy;
    rsp_i       = rspd;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " req_valid_o"}, 64'(req_valid_o), 64'd0);
    chk({tag, " req_o"},       64'(req_o),       64'd0);
    chk({tag, " rsp_valid_o"}, 64'(rsp_valid_o), 64'd0);
    chk({tag, " rsp_ready_o"}, 64'(rsp_ready_o), 64'd0);
    chk({tag, " eh_valid_o"},  64'(eh_valid_o),  64'd0);
    chk({tag, " eh_ready_o"},  64'(eh_ready_o),  64'd0);
    chk({tag, " busy_o"},      64'(busy_o),      64'd0);
  endtask

  initial begin
    logic [RW-1:0] exp_req;
    rst_ni     = 1'b0;
    req_i      = {P1, P0};
    eh_req_i   = '0;
    eh_valid_i = '0;
    eh_ready_i = 1'b0;
    drive(2'b00, 1'b0, 1'b0, 2'b00, 32'h0);

    // Vector table: one row per cycle, outputs checked before the edge.
    // Round robin with both frontends valid: grants 0,1,0,1 then full.
    add(2'b11, 1, 0, 2'b00, 32'h0,  1, 2'b01, 0, 2'b00, 0, 0);
    add(2'b11, 1, 0, 2'b00, 32'h0,  1, 2'b10, 1, 2'b00, 0, 1);
    add(2'b11, 1, 0, 2'b00, 32'h0,  1, 2'b01, 0, 2'b00, 0, 1);
    add(2'b11, 1, 0, 2'b00, 32'h0,  1, 2'b10, 1, 2'b00, 0, 1);
    add(2'b11, 1, 0, 2'b00, 32'h0,  0, 2'b00, 2, 2'b00, 0, 1);
    // Pop while full: still no push this cycle, owner 0 gets the response.
    add(2'b11, 1, 1, 2'b11, 32'h1,  0, 2'b00, 2, 2'b01, 1, 1);
    // Following cycle a push is allowed again (prio back at 0).
    add(2'b11, 1, 0, 2'b00, 32'h0,  1, 2'b01, 0, 2'b00, 0, 1);
    // Drain: FIFO holds 1,0,1,0.
    add(2'b00, 0, 1, 2'b11, 32'h2,  0, 2'b00, 2, 2'b10, 1, 1);
    add(2'b00, 0, 1, 2'b01, 32'h3,  0, 2'b00, 2, 2'b01, 1, 1);
    add(2'b00, 0, 1, 2'b01, 32'h4,  0, 2'b00, 2, 2'b10, 0, 1);
    add(2'b00, 0, 1, 2'b10, 32'h5,  0, 2'b00, 2, 2'b10, 1, 1);
    add(2'b00, 0, 1, 2'b11, 32'h6,  0, 2'b00, 2, 2'b01, 1, 1);
    add(2'b00, 0, 1, 2'b11, 32'h7,  0, 2'b00, 2, 2'b00, 0, 0);
    // Grant 1 (prio 1) so prio returns to 0, then lock on frontend 1.
    add(2'b10, 1, 0, 2'b00, 32'h0,  1, 2'b10, 1, 2'b00, 0, 0);
    add(2'b10, 0, 0, 2'b00, 32'h0,  1, 2'b00, 1, 2'b00, 0, 1);
    add(2'b11, 0, 0, 2'b00, 32'h0,  1, 2'b00, 1, 2'b00, 0, 1);
    add(2'b11, 0, 0, 2'b00, 32'h0,  1, 2'b00, 1, 2'b00, 0, 1);
    add(2'b11, 1, 0, 2'b00, 32'h0,  1, 2'b10, 1, 2'b00, 0, 1);
    add(2'b01, 1, 0, 2'b00, 32'h0,  1, 2'b01, 0, 2'b00, 0, 1);
    add(2'b10, 1, 0, 2'b00, 32'h0,  1, 2'b10, 1, 2'b00, 0, 1);
    // FIFO now 1,1,0,1: responses A,B,C,D routed to 1,1,0,1.
    add(2'b00, 0, 1, 2'b11, 32'hA,  0, 2'b00, 2, 2'b10, 1, 1);
    add(2'b00, 0, 1, 2'b11, 32'hB,  0, 2'b00, 2, 2'b10, 1, 1);
    add(2'b00, 0, 1, 2'b11, 32'hC,  0, 2'b00, 2, 2'b01, 1, 1);
    add(2'b00, 0, 1, 2'b11, 32'hD,  0, 2'b00, 2, 2'b10, 1, 1);
    add(2'b00, 0, 1, 2'b11, 32'hE,  0, 2'b00, 2, 2'b00, 0, 0);

    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_ni = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i].rv, vq[i].rdy, vq[i].rspv, vq[i].rsprdy, vq[i].rspd);
      #1;
      exp_req = (vq[i].e_sel == 0) ? P0 : (vq[i].e_sel == 1) ? P1 : '0;
      chk($sformatf("v%0d req_valid_o", i), 64'(req_valid_o), 64'(vq[i].e_rvo));
      chk($sformatf("v%0d req_ready_o", i), 64'(req_ready_o), 64'(vq[i].e_rro));
      chk($sformatf("v%0d req_o", i),       64'(req_o),       64'(exp_req));
      chk($sformatf("v%0d rsp_valid_o", i), 64'(rsp_valid_o), 64'(vq[i].e_rspvo));
      chk($sformatf("v%0d rsp_ready_o", i), 64'(rsp_ready_o), 64'(vq[i].e_rspro));
      chk($sformatf("v%0d rsp_o", i),       64'(rsp_o),       64'(vq[i].rspd));
      chk($sformatf("v%0d busy_o", i),      64'(busy_o),      64'(vq[i].e_busy));
    end

    // Error handling: head owner = 1, both frontends request ABORT.
    @(negedge clk);
    drive(2'b10, 1'b1, 1'b0, 2'b00, 32'h0);
    #1;
    chk("eh setup req_ready_o", 64'(req_ready_o), 64'b10);
    @(negedge clk);
    drive(2'b00, 1'b0, 1'b0, 2'b00, 32'h0);
    eh_valid_i = 2'b11;
    eh_req_i   = 2'b11;
    eh_ready_i = 1'b1;
    #1;
`ifdef IDMA_ARB_ERROR_HANDLING_EN
    chk("eh_valid_o", 64'(eh_valid_o), 64'd1);
    chk("eh_req_o",   64'(eh_req_o),   64'(ABORT));
    chk("eh_ready_o", 64'(eh_ready_o), 64'b10);
`else
    chk("eh_valid_o", 64'(eh_valid_o), 64'd0);
    chk("eh_req_o",   64'(eh_req_o),   64'(CONTINUE));
    chk("eh_ready_o", 64'(eh_ready_o), 64'b00);
`endif
    @(negedge clk);
    eh_valid_i = '0;
    eh_req_i   = '0;
    eh_ready_i = 1'b0;
    drive(2'b00, 1'b0, 1'b1, 2'b10, 32'hF);
    #1;
    chk("eh after rsp_valid_o", 64'(rsp_valid_o), 64'b10);
    chk("eh after rsp_ready_o", 64'(rsp_ready_o), 64'd1);
    @(negedge clk);
    drive(2'b00, 1'b0, 1'b0, 2'b00, 32'h0);
    #1;
    chk("eh drained busy_o", 64'(busy_o), 64'd0);

    // Reset with three transfers outstanding (prio 0: grants 0,1,0).
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(2'b11, 1'b1, 1'b0, 2'b00, 32'h0);
      #1;
      chk($sformatf("pre-reset grant %0d", i), 64'(req_ready_o),
          (i == 1) ? 64'b10 : 64'b01);
    end
    @(negedge clk);
    drive(2'b00, 1'b0, 1'b0, 2'b00, 32'h0);
    #1;
    chk("pre-reset busy_o", 64'(busy_o), 64'd1);
    rst_ni = 1'b0;
    @(negedge clk);
    #1;
    chk_reset_outputs("mid reset");
    rst_ni = 1'b1;
    @(negedge clk);
    drive(2'b00, 1'b0, 1'b1, 2'b11, 32'h9);
    #1;
    chk("post-reset busy_o",      64'(busy_o),      64'd0);
    chk("post-reset rsp_ready_o", 64'(rsp_ready_o), 64'd0);
    chk("post-reset rsp_valid_o", 64'(rsp_valid_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/idma_req_arbiter.md
# idma_req_arbiter

Shares one iDMA backend between `NumReq` frontends. Round-robin arbitration runs on the 1D request channel. A grant-ID FIFO records the owner of each accepted transfer, and the in-order backend responses go back to that owner. With error handling compiled in, error-handling actions (`idma_pkg::eh_action_e`) are taken only from the frontend that owns the oldest outstanding transfer. Sits between the frontends/midends and `idma_backend`.

## Interface
- `NumReq`, 2: number of frontends, ≥2
- `ReqWidth`, 64: width of the opaque packed request payload
- `RspWidth`, 32: width of the opaque packed response payload
- `NumOutstd`, 4: grant-FIFO depth (maximum outstanding transfers), power of two, ≥2
- `clk_i`  in  1  clock; all state updates on the rising edge
- `rst_ni`  in  1  reset, synchronous, active-low
- `req_i`  in  NumReq*ReqWidth  requests; slice i belongs to frontend i
- `req_valid_i`  in  NumReq  per-frontend valid
- `req_ready_o`  out  NumReq  per-frontend ready
- `req_o`  out  ReqWidth  request to the backend
- `req_valid_o`  out  1  valid to the backend
- `req_ready_i`  in  1  ready from the backend
- `rsp_i`  in  RspWidth  response from the backend
- `rsp_valid_i`  in  1  valid from the backend
- `rsp_ready_o`  out  1  ready to the backend
- `rsp_o`  out  RspWidth  `rsp_i`, broadcast to all frontends
- `rsp_valid_o`  out  NumReq  one-hot, owner only
- `rsp_ready_i`  in  NumReq  per-frontend response ready
- `eh_req_i`  in  NumReq  per-frontend `idma_eh_req_t`
- `eh_valid_i` / `eh_ready_o`  in/out  NumReq  error-handling handshake, per frontend
- `eh_req_o`, `eh_valid_o` / `eh_ready_i`  out/in  1  error-handling channel to the backend
- `busy_o`  out  1  FIFO non-empty or a grant is locked

## Operation
- Arbiter states:
  - `IDLE`: no grant held.
  - `LOCKED`: grant held on index `gnt_q`.
- `IDLE`:
  - Candidate = first valid frontend at or after `prio_q`, searching cyclically.
  - If the FIFO is not full: `req_valid_o` = 1, `req_o` = candidate payload, `req_ready_o[cand]` = `req_ready_i`.
  - No handshake → go to `LOCKED` with `gnt_q` = candidate.
  - Handshake → push candidate; `prio_q` ← candidate+1 (mod `NumReq`); stay in `IDLE`.
- `LOCKED`:
  - Only `gnt_q` is forwarded; no re-arbitration.
  - Handshake → push `gnt_q`; `prio_q` ← `gnt_q`+1; go to `IDLE`.
- Frontend protocol: a frontend must not drop valid before its handshake. Valid/payload stability toward the backend is therefore preserved.
- FIFO full:
  - `req_valid_o` = 0 and all `req_ready_o` = 0.
  - The lock is held.
  - A pop in the same cycle does not enable a push; there is no full-bypass.
- Response path:
  - Owner = FIFO head.
  - `rsp_valid_o[head]` = `rsp_valid_i`.
  - `rsp_ready_o` = `rsp_ready_i[head]`.
  - A handshake pops the head.
- FIFO empty:
  - `rsp_ready_o` = 0 and `rsp_valid_o` = 0.
  - A push in the same cycle does not forward; there is no empty-bypass.
- FIFO pointers are `$clog2(NumOutstd)`+1 bits and wrap naturally. Full = MSBs differ and LSBs are equal.

## Timing
- Request path: combinational, zero-latency pass-through. A grant becomes visible in the same cycle as valid.
- Response routing: combinational from the FIFO head. A pushed entry becomes routable on the next cycle.
- Reset values:
  - State `IDLE`, `prio_q` = 0, FIFO empty.
  - Outputs: `req_valid_o` = 0, all `rsp_valid_o` = 0, `rsp_ready_o` = 0, `eh_valid_o` = 0, all `eh_ready_o` = 0, `busy_o` = 0, `req_o` = 0.
- Reset mid-transfer: all outstanding ownership is discarded. The backend must be reset together with this block.

## Configuration
- `IDMA_ARB_ERROR_HANDLING_EN` defined:
  - `eh_valid_o` = `eh_valid_i[head]` and `eh_req_o` = `eh_req_i[head]`, gated by FIFO non-empty.
  - `eh_ready_o[head]` = `eh_ready_i`; all other `eh_ready_o` = 0.
  - An `ABORT` does not pop; the backend's error response pops.
- Not defined:
  - `eh_valid_o` = 0, `eh_req_o` = `CONTINUE`, all `eh_ready_o` = 0.
  - `eh_*` inputs are ignored.

## Structure
- Add `arb_state_e` (`IDLE`, `LOCKED`) to `idma_pkg`.
- Add `ARB_MAX_REQ` = 16 to `idma_pkg`; elaboration assertion `NumReq` ≤ `ARB_MAX_REQ`.
- One sub-module: `idma_arb_id_fifo`, holding `$clog2(NumReq)`-bit entries with push/pop/full/empty.

## Test plan
- Config `NumReq`=2, `NumOutstd`=4, backend always ready. Both frontends valid continuously for 4 cycles → grants in order 0,1,0,1; `prio_q` = 0 afterwards.
- Frontend 1 valid, backend `req_ready_i` held 0 for 3 cycles. Frontend 0 raises valid in cycle 1 → `req_o` stays frontend 1 payload; frontend 0 is not granted until frontend 1's handshake.
- 4 requests accepted, no responses → `req_valid_o` = 0 and all `req_ready_o` = 0.
  - Next: response pop → push allowed from the following cycle.
- Grants order 1,0,1; three responses with values 0xA,0xB,0xC → `rsp_valid_o` = 0b10, 0b01, 0b10 respectively.
- `IDMA_ARB_ERROR_HANDLING_EN` defined, head owner = 1. Both frontends assert `ABORT` → only `eh_ready_o[1]` = 1; `eh_req_o` = `ABORT`; FIFO unchanged.
- Reset asserted with 3 outstanding, then released → `busy_o` = 0; the next response is not accepted (`rsp_ready_o` = 0).
